dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
- Parametrised single-clock data-memory controller. Successor to the two-clock byte-lane dmem.
- Owns an internal word array and takes load/store requests from the CPU through a valid/ready handshake.
- Uses the same 3-bit memop encoding (lb/lh/lw/lbu/lhu, sb/sh/sw).
- New relative to the predecessor: configurable depth, hardware split of word-crossing misaligned accesses into two beats, explicit response strobe, and error signalling.

Parameters:
- DEPTH_LOG2, 15, log2 of word count. The word index is req_addr[DEPTH_LOG2+1:2]; higher address bits are ignored.
- MISALIGN_EN, 1, 1 = word-crossing accesses are split into two beats; 0 = they are rejected with rsp_err.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request; equals (state==IDLE) && !rst.
- req_we  input  1  1 = store, 0 = load.
- req_memop  input  3  000 b, 001 h, 010 w, 100 bu, 101 hu; other codes are illegal.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  32  load result; 0 for stores and errors.
- rsp_err  output  1  qualifies rsp_valid; illegal memop or rejected misalignment.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Array contents are not reset.
  - rst asserted mid-operation abandons the request: no response is produced. A write already committed at an earlier edge stays committed.
- Handshake and latching:
  - Accept when req_valid && req_ready at a rising edge.
  - Latch we, memop, addr, wdata; off=addr[1:0]; size = 1/2/4 bytes from memop[1:0].
  - No response backpressure. Only one request is outstanding at a time.
- States: IDLE, BEAT1, BEAT2, RESP.
  - IDLE -> BEAT1 on accept.
  - IDLE -> RESP directly on accept if memop is illegal, or if MISALIGN_EN=0 and off+size>4. Set err=1; no array access.
  - BEAT1: access word W=addr[DEPTH_LOG2+1:2]. Go to BEAT2 if off+size>4, else RESP.
  - BEAT2: access word (W+1) mod 2^DEPTH_LOG2, so the top word wraps to word 0. Then go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then IDLE. req_ready returns high the cycle after RESP.
- Latency, measured from the accept edge to the cycle in which rsp_valid=1:
  - 2 cycles for a single-beat access.
  - 3 cycles for a split access.
  - 1 cycle for an error.
- Store lanes:
  - S64 = zero-extended wdata << 8*off.
  - M8 = (size ones) << off.
  - Beat1 writes lanes M8[3:0] with S64[31:0].
  - Beat2 writes lanes M8[7:4] with S64[63:32].
  - Lanes outside the mask are untouched. A non-crossing misaligned half (off=01) completes in one beat.
- Load path:
  - Array read is synchronous; data is registered at the end of each beat.
  - L64 = {beat2 word, beat1 word}; beat2 word is 0 if there is no second beat.
  - R = L64 >> 8*off. Take the low size bytes.
  - memop[2]=0 sign-extends; memop[2]=1 zero-extends; lw is passed through unchanged.
  - rsp_rdata is registered and valid only while rsp_valid=1. It holds its value otherwise.
- Stores return rsp_rdata=0. An illegal memop with req_we=1 writes nothing.
- req_valid must be ignored when req_ready=0; changes on the request inputs after accept have no effect.

Test Plan:
1. sw 0x11223344 @0x100, then lw @0x100 -> rsp_valid 2 cycles after each accept; load rsp_rdata=0x11223344, rsp_err=0.
2. sb 0x80 @0x203 over word 0, then lb @0x203 -> 0xFFFFFF80; lbu @0x203 -> 0x00000080; lw @0x200 -> 0x80000000 (other lanes untouched).
3. MISALIGN_EN=1: sw 0xAABBCCDD @0x101, then lw @0x101 -> 3-cycle latency; words 0x100=0xBBCCDDxx and 0x104=0xxxxxxxAA; load returns 0xAABBCCDD.
4. lh @0x003 after word0=0x12345678, word1=0x9ABCDEF0 -> rsp_rdata=0xFFFFF012. Same access with MISALIGN_EN=0 -> rsp_err=1, rsp_rdata=0, 1-cycle latency, no write.
5. memop=011 store -> rsp_err=1 and array unchanged. sw to word 2^DEPTH_LOG2-1 at off=2 -> second beat writes word 0.
6. rst asserted during BEAT2 of a split store -> no rsp_valid; beat1 word written, word W+1 unchanged; req_ready=1 the first cycle after rst deasserts.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Single-clock data-memory controller with valid/ready request handshake.
// Loads/stores of byte, half and word; word-crossing accesses are split into
// two beats (or rejected when MISALIGN_EN=0). One request outstanding at a time.
module dmem_ctrl #(
    parameter int unsigned DEPTH_LOG2  = 15,
    parameter bit          MISALIGN_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_memop,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {StIdle, StBeat1, StBeat2, StResp} state_e;

    state_e                  r_state;
    logic                    r_we;
    logic [2:0]              r_memop;
    logic [1:0]              r_off;
    logic [DEPTH_LOG2-1:0]   r_idx;
    logic [31:0]             r_wdata;
    logic [31:0]             r_lo;
    logic                    r_rsp_valid;
    logic                    r_rsp_err;
    logic [31:0]             r_rsp_rdata;
    logic [31:0]             r_mem [DEPTH];

    logic                    w_accept;
    logic                    w_req_err;
    logic                    w_cross;
    logic [DEPTH_LOG2-1:0]   w_idx1;
    logic [63:0]             w_s64;
    logic [7:0]              w_m8;
    logic [31:0]             w_lo_nxt;
    logic [31:0]             w_hi_nxt;
    logic [63:0]             w_r64;
    logic [31:0]             w_load;
    logic                    w_wr_en;
    logic [DEPTH_LOG2-1:0]   w_wr_idx;
    logic [3:0]              w_wr_mask;
    logic [31:0]             w_wr_data;
    logic                    w_unused;

    // Access size in bytes from memop[1:0].
    function automatic logic [2:0] size_of(input logic [1:0] op);
        case (op)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Byte-lane mask of the access before shifting by the offset.
    function automatic logic [3:0] mask_of(input logic [1:0] op);
        case (op)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Legal codes: 000, 001, 010, 100, 101.
    function automatic logic legal(input logic [2:0] op);
        return (op[1:0] != 2'b11) && !(op[2] && op[1]);
    endfunction

    function automatic logic crosses(input logic [1:0] off, input logic [2:0] op);
        logic [3:0] sum;
        sum = {2'b00, off} + {1'b0, size_of(op[1:0])};
        return sum > 4'd4;
    endfunction

    assign w_accept  = req_valid && req_ready;
    assign w_req_err = !legal(req_memop) || (!MISALIGN_EN && crosses(req_addr[1:0], req_memop));
    assign w_cross   = crosses(r_off, r_memop);
    assign w_idx1    = r_idx + DEPTH_LOG2'(1);  // wraps from the top word to word 0
    assign w_s64     = {32'b0, r_wdata} << {r_off, 3'b000};
    assign w_m8      = {4'b0000, mask_of(r_memop[1:0])} << r_off;

    // Word read in the current beat; the beat-1 word is kept in r_lo for a second beat.
    assign w_lo_nxt  = (r_state == StBeat1) ? r_mem[r_idx] : r_lo;
    assign w_hi_nxt  = (r_state == StBeat2) ? r_mem[w_idx1] : 32'b0;
    assign w_r64     = {w_hi_nxt, w_lo_nxt} >> {r_off, 3'b000};

    assign w_unused  = ^{req_addr[31:DEPTH_LOG2+2], w_r64[63:32]};

    // Extract the low size bytes and sign/zero-extend them.
    always_comb begin
        w_load = w_r64[31:0];
        case (r_memop[1:0])
            2'b00:   w_load = {{24{w_r64[7] & ~r_memop[2]}}, w_r64[7:0]};
            2'b01:   w_load = {{16{w_r64[15] & ~r_memop[2]}}, w_r64[15:0]};
            default: w_load = w_r64[31:0];
        endcase
    end

    // Select word, lanes and data of the store beat in progress.
    always_comb begin
        w_wr_en   = !rst && r_we && ((r_state == StBeat1) || (r_state == StBeat2));
        w_wr_idx  = r_idx;
        w_wr_mask = w_m8[3:0];
        w_wr_data = w_s64[31:0];
        if (r_state == StBeat2) begin
            w_wr_idx  = w_idx1;
            w_wr_mask = w_m8[7:4];
            w_wr_data = w_s64[63:32];
        end
    end

    // Byte-lane array writes; a reset at the same edge suppresses the beat.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (w_wr_mask[i]) begin
                    r_mem[w_wr_idx][8*i +: 8] <= w_wr_data[8*i +: 8];
                end
            end
        end
    end

    // Request FSM with registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_we    <= req_we;
                        r_memop <= req_memop;
                        r_off   <= req_addr[1:0];
                        r_idx   <= req_addr[DEPTH_LOG2+1:2];
                        r_wdata <= req_wdata;
                        if (w_req_err) begin
                            r_state     <= StResp;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= 32'b0;
                        end else begin
                            r_state <= StBeat1;
                        end
                    end
                end
                StBeat1: begin
                    r_lo <= w_lo_nxt;
                    if (w_cross) begin
                        r_state <= StBeat2;
                    end else begin
                        r_state     <= StResp;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_we ? 32'b0 : w_load;
                    end
                end
                StBeat2: begin
                    r_state     <= StResp;
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= r_we ? 32'b0 : w_load;
                end
                StResp: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign req_ready = (r_state == StIdle) && !rst;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: byte-addressed reference model, scoreboard queue and a
// separate monitor for the misalignment-enabled instance; directed checks for
// a second instance with misalignment rejected.
module tb_dmem_ctrl;

    localparam int DL2 = 8;
    localparam int NB  = 4 << DL2;  // bytes in the array

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_valid, a_ready, a_we, a_rsp_valid, a_rsp_err;
    logic [2:0]  a_op;
    logic [31:0] a_addr, a_wdata, a_rsp_rdata;
    logic        b_valid, b_ready, b_we, b_rsp_valid, b_rsp_err;
    logic [2:0]  b_op;
    logic [31:0] b_addr, b_wdata, b_rsp_rdata;

    dmem_ctrl #(.DEPTH_LOG2(DL2), .MISALIGN_EN(1'b1)) u_dut_a (
        .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
        .req_memop(a_op), .req_addr(a_addr), .req_wdata(a_wdata), .rsp_valid(a_rsp_valid),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    dmem_ctrl #(.DEPTH_LOG2(DL2), .MISALIGN_EN(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
        .req_memop(b_op), .req_addr(b_addr), .req_wdata(b_wdata), .rsp_valid(b_rsp_valid),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t       q[$];
    logic [7:0] mb [2][NB];  // byte image per instance
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: byte-granular memory, address taken modulo the array size.
    task automatic model(input int sel, input bit mis, input logic we, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err, output int lat);
        int size, off, base, idx;
        bit ok;
        logic [31:0] v;
        ok   = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd5);
        size = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
        off  = int'(addr[1:0]);
        base = int'(addr % NB);
        rd   = 32'b0;
        err  = 1'b0;
        v    = 32'b0;
        if (!ok || (!mis && off + size > 4)) begin
            err = 1'b1;
            lat = 1;
            return;
        end
        lat = (off + size > 4) ? 3 : 2;
        for (int k = 0; k < size; k++) begin
            idx = (base + k) % NB;
            if (we) mb[sel][idx] = wd[8*k +: 8];
            else    v[8*k +: 8] = mb[sel][idx];
        end
        if (!we) begin
            if (size < 4 && !op[2] && v[8*size-1]) begin
                for (int k = size; k < 4; k++) v[8*k +: 8] = 8'hFF;
            end
            rd = v;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Pops the scoreboard whenever instance A presents a response.
    task automatic monitor_a();
        exp_t e;
        int   lat;
        forever begin
            @(negedge clk);
            if (a_rsp_valid === 1'b1) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp_a: unexpected response rdata=%h err=%b, none required",
                             a_rsp_rdata, a_rsp_err);
                end else begin
                    e   = q.pop_front();
                    lat = cyc - e.acc + 1;
                    if (a_rsp_rdata !== e.rd || a_rsp_err !== e.err || lat != e.lat) begin
                        n_fail++;
                        $display("FAIL rsp_a: got rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=%0d",
                                 a_rsp_rdata, a_rsp_err, lat, e.rd, e.err, e.lat);
                    end
                end
            end
        end
    endtask

    task automatic wait_ready_a();
        int g = 0;
        while (a_ready !== 1'b1) begin
            @(negedge clk);
            g++;
            if (g > 20) begin
                $display("FAIL ready_a: req_ready low for 20 cycles, required 1");
                $fatal(1, "ready timeout");
            end
        end
    endtask

    // Issue one request to A; junk with valid=1 is driven while it is busy.
    task automatic issue_a(input logic we, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wd);
        exp_t e;
        a_valid = 1'b1; a_we = we; a_op = op; a_addr = addr; a_wdata = wd;
        wait_ready_a();
        @(posedge clk);
        #1;
        e.acc = cyc;
        model(0, 1'b1, we, op, addr, wd, e.rd, e.err, e.lat);
        q.push_back(e);
        @(negedge clk);
        a_valid = 1'b1; a_we = 1'($urandom); a_op = 3'($urandom);
        a_addr = $urandom; a_wdata = $urandom;
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    // Blocking request/response on instance B.
    task automatic issue_b(input logic we, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, input string name);
        logic [31:0] erd;
        logic        eerr;
        int          elat, acc, g;
        b_valid = 1'b1; b_we = we; b_op = op; b_addr = addr; b_wdata = wd;
        g = 0;
        while (b_ready !== 1'b1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        model(1, 1'b0, we, op, addr, wd, erd, eerr, elat);
        @(negedge clk);
        b_valid = 1'b0;
        g = 0;
        while (b_rsp_valid !== 1'b1 && g < 10) begin
            @(negedge clk);
            g++;
        end
        n_tests++;
        if (b_rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: no response within 10 cycles, required one", name);
        end else if (b_rsp_rdata !== erd || b_rsp_err !== eerr || cyc - acc + 1 != elat) begin
            n_fail++;
            $display("FAIL %s: got rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=%0d",
                     name, b_rsp_rdata, b_rsp_err, cyc - acc + 1, erd, eerr, elat);
        end
        @(negedge clk);
    endtask

    logic [2:0]  legal_ops [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [2:0]  bad_ops [3]   = '{3'd3, 3'd6, 3'd7};

    initial begin
        logic [31:0] wd;
        logic [2:0]  op;
        int          g;
        a_valid = 1'b0; a_we = 1'b0; a_op = 3'd0; a_addr = 32'd0; a_wdata = 32'd0;
        b_valid = 1'b0; b_we = 1'b0; b_op = 3'd0; b_addr = 32'd0; b_wdata = 32'd0;
        fork
            monitor_a();
        join_none

        repeat (3) @(negedge clk);
        chk("reset ready_a", 32'(a_ready), 32'd0);
        chk("reset rsp_valid_a", 32'(a_rsp_valid), 32'd0);
        chk("reset rsp_rdata_a", a_rsp_rdata, 32'd0);
        chk("reset rsp_err_a", 32'(a_rsp_err), 32'd0);
        chk("reset ready_b", 32'(b_ready), 32'd0);
        chk("reset rsp_valid_b", 32'(b_rsp_valid), 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_a after reset", 32'(a_ready), 32'd1);
        chk("ready_b after reset", 32'(b_ready), 32'd1);
        @(negedge clk);

        // Fill the whole array so every later load has defined data.
        for (int i = 0; i < NB / 4; i++) issue_a(1'b1, 3'd2, 32'(i * 4), $urandom);

        issue_a(1'b1, 3'd2, 32'h100, 32'h11223344);
        issue_a(1'b0, 3'd2, 32'h100, 32'h0);
        issue_a(1'b1, 3'd2, 32'h200, 32'h0);
        issue_a(1'b1, 3'd0, 32'h203, 32'h80);
        issue_a(1'b0, 3'd0, 32'h203, 32'h0);
        issue_a(1'b0, 3'd4, 32'h203, 32'h0);
        issue_a(1'b0, 3'd2, 32'h200, 32'h0);
        issue_a(1'b1, 3'd2, 32'h101, 32'hAABBCCDD);
        issue_a(1'b0, 3'd2, 32'h101, 32'h0);
        issue_a(1'b0, 3'd2, 32'h100, 32'h0);
        issue_a(1'b0, 3'd2, 32'h104, 32'h0);
        issue_a(1'b1, 3'd2, 32'h0, 32'h12345678);
        issue_a(1'b1, 3'd2, 32'h4, 32'h9ABCDEF0);
        issue_a(1'b0, 3'd1, 32'h3, 32'h0);
        issue_a(1'b0, 3'd5, 32'h3, 32'h0);
        issue_a(1'b0, 3'd1, 32'h1, 32'h0);
        issue_a(1'b1, 3'd3, 32'h40, 32'hDEADBEEF);
        issue_a(1'b0, 3'd2, 32'h40, 32'h0);
        issue_a(1'b1, 3'd2, 32'(NB - 2), 32'hCAFEF00D);
        issue_a(1'b0, 3'd2, 32'(NB - 4), 32'h0);
        issue_a(1'b0, 3'd2, 32'h0, 32'h0);
        issue_a(1'b0, 3'd2, 32'(NB - 2), 32'h0);
        issue_a(1'b0, 3'd2, 32'hFFFF_F000 | 32'h101, 32'h0);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) op = bad_ops[$urandom_range(0, 2)];
            else op = legal_ops[$urandom_range(0, 4)];
            issue_a(1'($urandom_range(0, 2) == 0), op, $urandom, $urandom);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        // Instance with word-crossing accesses rejected.
        issue_b(1'b1, 3'd2, 32'h0, 32'h12345678, "b sw @0");
        issue_b(1'b1, 3'd2, 32'h4, 32'h9ABCDEF0, "b sw @4");
        issue_b(1'b0, 3'd1, 32'h3, 32'h0, "b lh @3 rejected");
        issue_b(1'b1, 3'd1, 32'h3, 32'h0000FFFF, "b sh @3 rejected");
        issue_b(1'b1, 3'd2, 32'h6, 32'h55555555, "b sw @6 rejected");
        issue_b(1'b1, 3'd7, 32'h0, 32'hFFFFFFFF, "b illegal store");
        issue_b(1'b0, 3'd2, 32'h0, 32'h0, "b lw @0 unchanged");
        issue_b(1'b0, 3'd2, 32'h4, 32'h0, "b lw @4 unchanged");
        issue_b(1'b0, 3'd5, 32'h1, 32'h0, "b lhu @1 in-word");
        issue_b(1'b0, 3'd0, 32'h7, 32'h0, "b lb @7");

        // Reset during the second beat of a split store to word 10, offset 1.
        wd = $urandom;
        a_valid = 1'b1; a_we = 1'b1; a_op = 3'd2; a_addr = 32'h29; a_wdata = wd;
        wait_ready_a();
        @(posedge clk);
        #1;
        @(negedge clk);
        a_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_a during rst", 32'(a_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_a after mid-op rst", 32'(a_ready), 32'd1);
        for (int k = 0; k < 3; k++) mb[0][16'h29 + k] = wd[8*k +: 8];
        @(negedge clk);
        issue_a(1'b0, 3'd2, 32'h28, 32'h0);
        issue_a(1'b0, 3'd2, 32'h2C, 32'h0);

        g = 0;
        while (q.size() != 0 && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_a: %0d responses outstanding, required 0", q.size());
        end
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
